imem_boot_ctrl: RTL and testbench
=================================

Name: imem_boot_ctrl

Overview:
Boot loader and port controller for the CPU's single-port instruction memory. It receives a byte stream, packs it little-endian into 32-bit words and writes them to instruction memory while the core is held idle. It then releases the core via cpu_run and serves its fetch requests from the same memory port. It sits between the instruction-memory array and the fetch stage of cpu_top.

Parameters:
ADDR_W, 8, word-address width; memory depth DEPTH = 2**ADDR_W words (256 words = 1024 bytes)
NOP_WORD, 32'h00000013, word returned on a faulting fetch

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
load_start  in  1  begin a (re)load
byte_valid  in  1  byte stream valid
byte_data  in  8  byte stream data
byte_last  in  1  marks the final byte of the image; qualified by a byte handshake
byte_ready  out  1  loader can accept a byte
fetch_req  in  1  fetch request from core
fetch_addr  in  32  fetch byte address
fetch_valid  out  1  fetch response valid
fetch_data  out  32  fetch response word
fetch_fault  out  1  response is misaligned or out-of-range
fetch_stall  out  1  high whenever state != RUN
mem_we  out  1  memory write enable
mem_re  out  1  memory read enable
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, synchronous, 1-cycle latency
cpu_run  out  1  core enable
load_done  out  1  one-cycle pulse on entering RUN
load_err  out  1  sticky overflow flag
word_count  out  ADDR_W+1  words written by the most recent load

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs 0, except fetch_stall = 1.
  - Byte lane counter, word pointer and assembly register cleared.
  - A partially assembled word is discarded; no mem_we is issued after reset.
- States: IDLE, LOAD, FLUSH, RUN.
- IDLE:
  - byte_ready = 0; fetch_req is ignored.
  - load_start -> LOAD next cycle. On that entry: clear load_err, word_count, word pointer and lane counter.
- LOAD:
  - byte_ready = 1.
  - An accepted byte (byte_valid & byte_ready) goes to lane lane_cnt: lane 0 = bits 7:0, lane 3 = bits 31:24. lane_cnt then increments mod 4.
  - Accepting lane 3 without byte_last: in the next cycle, mem_we = 1, mem_addr = word_ptr, mem_wdata = the assembled word; word_ptr and word_count increment.
  - byte_ready stays 1 during that write cycle, so back-to-back bytes are sustained at 1 byte/cycle.
  - Accepting any byte with byte_last -> FLUSH. Unfilled upper lanes are written as zero.
- FLUSH (one cycle):
  - byte_ready = 0.
  - Issues the final write: mem_we = 1, padded word; word_count increments.
  - -> RUN next cycle. The first RUN cycle has cpu_run = 1 and load_done = 1 for exactly that cycle.
- Overflow:
  - A byte accepted while word_ptr == DEPTH is discarded.
  - load_err = 1 from the next cycle, and it is sticky. State -> IDLE; cpu_run stays 0; memory is not written.
  - This applies even if the overflowing byte carries byte_last.
- RUN:
  - cpu_run = 1, fetch_stall = 0, byte_ready = 0.
  - fetch_req: in the same cycle, mem_re = 1 and mem_addr = fetch_addr[ADDR_W+1:2] (combinational).
  - In the next cycle, fetch_valid = 1 and fetch_data = mem_rdata.
  - Throughput is 1 fetch/cycle.
- Fetch fault:
  - Condition: fetch_addr[1:0] != 0, or fetch_addr[31:ADDR_W+2] != 0.
  - mem_re = 0.
  - Next cycle: fetch_valid = 1, fetch_fault = 1, fetch_data = NOP_WORD.
  - fetch_fault is 0 on every other cycle.
- load_start in RUN:
  - A fetch accepted in the same cycle still completes next cycle.
  - State -> LOAD next cycle; cpu_run drops in that cycle; fetch_req is ignored from then on.
- load_start in LOAD or FLUSH: ignored.
- mem_we and mem_re are never both 1. mem_addr and mem_wdata are don't-care when neither is asserted.

Test Plan:
1. Reset held 3 cycles, then released with no stimulus -> state IDLE; cpu_run = 0, fetch_stall = 1, byte_ready = 0, mem_we = 0, mem_re = 0, load_err = 0, word_count = 0.
2. load_start, then bytes 13 00 00 00 93 00 10 00 streamed back-to-back with byte_last on the 8th ->
   - mem[0] = 32'h00000013, written the cycle after byte 4.
   - mem[1] = 32'h00100093, written in FLUSH.
   - word_count = 2; load_done pulses once; cpu_run = 1.
3. Partial final word: bytes 11 22 33 44 55, byte_last on 55, with byte_valid gaps -> mem[0] = 32'h44332211, mem[1] = 32'h00000055, word_count = 2.
4. Fetches in RUN:
   - fetch_addr 0x4 -> mem_re = 1, mem_addr = 1; next cycle fetch_valid = 1, fetch_data = 32'h00100093.
   - fetch_addr 0x6 -> fetch_fault = 1, fetch_data = 32'h00000013, mem_re = 0.
   - fetch_addr 0x400 -> fault.
   - Back-to-back requests each produce one response per cycle.
5. Overflow: 1025 bytes, no byte_last -> 256 writes; on byte 1025, load_err = 1 and state IDLE; cpu_run = 0. A subsequent load_start clears load_err.
6. Reset after 3 bytes of a load -> no mem_we ever; all outputs at reset values. A following 4-byte load writes mem[0] correctly. In RUN, load_start together with fetch_req -> the fetch response returns next cycle; cpu_run = 0 in the same cycle.

Source files
------------

// File: rtl/imem_boot_ctrl.sv
// Boot loader and port arbiter for the single-port instruction memory: packs a byte
// stream into little-endian words while the core is held, then serves core fetches.
module imem_boot_ctrl #(
    parameter int unsigned ADDR_W   = 8,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_valid,
    output logic [31:0]       fetch_data,
    output logic              fetch_fault,
    output logic              fetch_stall,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              cpu_run,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_reg;
    logic [1:0]        lane_cnt_reg;
    logic [ADDR_W:0]   word_ptr_reg;
    logic [ADDR_W:0]   word_count_reg;
    logic [31:0]       asm_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [31:0]       wr_data_reg;
    logic              load_err_reg;
    logic              load_done_reg;
    logic              fetch_valid_reg;
    logic              fetch_fault_reg;

    logic [31:0]       word_next;
    logic              byte_accept;
    logic              ptr_full;
    logic              word_close;
    logic              fetch_go;
    logic              fetch_bad;

    assign byte_ready  = (state_reg == LOAD);
    assign byte_accept = byte_valid & byte_ready;
    // word_ptr never exceeds DEPTH, so its MSB alone marks a full memory
    assign ptr_full    = word_ptr_reg[ADDR_W];
    assign word_close  = byte_last | (lane_cnt_reg == 2'd3);

    // Lanes below the current one keep assembled bytes, lanes above read as zero,
    // which gives the zero padding of a short final word for free.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign word_next[8*gi +: 8] =
                (lane_cnt_reg == 2'(gi)) ? byte_data :
                (lane_cnt_reg >  2'(gi)) ? asm_reg[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign fetch_go  = (state_reg == RUN) & fetch_req;
    assign fetch_bad = (fetch_addr[1:0] != 2'b00) | (fetch_addr[31:ADDR_W+2] != '0);

    assign mem_re    = fetch_go & ~fetch_bad;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_re ? fetch_addr[ADDR_W+1:2] : wr_addr_reg;
    assign mem_wdata = wr_data_reg;

    assign fetch_valid = fetch_valid_reg;
    assign fetch_fault = fetch_fault_reg;
    assign fetch_data  = !fetch_valid_reg ? 32'h0 :
                         fetch_fault_reg  ? NOP_WORD : mem_rdata;
    assign fetch_stall = (state_reg != RUN);
    assign cpu_run     = (state_reg == RUN);
    assign load_done   = load_done_reg;
    assign load_err    = load_err_reg;
    assign word_count  = word_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            lane_cnt_reg    <= 2'd0;
            word_ptr_reg    <= '0;
            word_count_reg  <= '0;
            asm_reg         <= 32'h0;
            mem_we_reg      <= 1'b0;
            wr_addr_reg     <= '0;
            wr_data_reg     <= 32'h0;
            load_err_reg    <= 1'b0;
            load_done_reg   <= 1'b0;
            fetch_valid_reg <= 1'b0;
            fetch_fault_reg <= 1'b0;
        end else begin
            mem_we_reg      <= 1'b0;
            load_done_reg   <= 1'b0;
            fetch_valid_reg <= fetch_go;
            fetch_fault_reg <= fetch_go & fetch_bad;
            if (mem_we_reg) begin
                word_count_reg <= word_count_reg + PTR_ONE;
            end

            case (state_reg)
                IDLE, RUN: begin
                    if (load_start) begin
                        state_reg      <= LOAD;
                        load_err_reg   <= 1'b0;
                        word_count_reg <= '0;
                        word_ptr_reg   <= '0;
                        lane_cnt_reg   <= 2'd0;
                        asm_reg        <= 32'h0;
                    end
                end
                LOAD: begin
                    if (byte_accept) begin
                        if (ptr_full) begin
                            load_err_reg <= 1'b1;
                            state_reg    <= IDLE;
                        end else begin
                            asm_reg      <= word_next;
                            lane_cnt_reg <= lane_cnt_reg + 2'd1;
                            // The pointer advances at acceptance so the byte after the
                            // last fitting word is already seen as overflow.
                            if (word_close) begin
                                mem_we_reg   <= 1'b1;
                                wr_addr_reg  <= word_ptr_reg[ADDR_W-1:0];
                                wr_data_reg  <= word_next;
                                word_ptr_reg <= word_ptr_reg + PTR_ONE;
                            end
                            if (byte_last) begin
                                state_reg <= FLUSH;
                            end
                        end
                    end
                end
                FLUSH: begin
                    state_reg     <= RUN;
                    load_done_reg <= 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl with a behavioural 1-cycle-latency memory attached.
module tb_imem_boot_ctrl;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_last;
    logic              byte_ready;
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_valid;
    logic [31:0]       fetch_data;
    logic              fetch_fault;
    logic              fetch_stall;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              cpu_run;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   word_count;

    logic [31:0] mem [0:255];
    int          wr_cnt = 0;
    int          wr_base;
    int          n_vec = 0;
    int          n_err = 0;

    imem_boot_ctrl #(.ADDR_W(ADDR_W), .NOP_WORD(32'h00000013)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_valid(fetch_valid),
        .fetch_data (fetch_data),
        .fetch_fault(fetch_fault),
        .fetch_stall(fetch_stall),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .cpu_run    (cpu_run),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
        end
        if (mem_re) begin
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = last;
        tick();
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    logic [7:0] img2   [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    logic [7:0] img3_d [8] = '{8'h11, 8'h00, 8'h22, 8'h33, 8'h00, 8'h00, 8'h44, 8'h55};
    logic       img3_v [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] img6   [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    initial begin
        reset = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        byte_last = 1'b0; fetch_req = 1'b0; fetch_addr = 32'h0;

        // reset state
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_cpu_run", cpu_run, 0);
        check("rst_stall", fetch_stall, 1);
        check("rst_byte_ready", byte_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_re", mem_re, 0);
        check("rst_load_err", load_err, 0);
        check("rst_word_count", word_count, 0);
        check("rst_fetch_valid", fetch_valid, 0);
        $display("reset: outputs checked");

        // 8-byte image, back-to-back
        start_load();
        check("l2_byte_ready", byte_ready, 1);
        for (int i = 0; i < 8; i++) begin
            send_byte(img2[i], i == 7);
            if (i == 3) begin
                check("l2_w0_we", mem_we, 1);
                check("l2_w0_addr", mem_addr, 0);
                check("l2_w0_data", mem_wdata, 32'h00000013);
                check("l2_ready_in_write", byte_ready, 1);
            end
        end
        check("l2_flush_we", mem_we, 1);
        check("l2_flush_addr", mem_addr, 1);
        check("l2_flush_data", mem_wdata, 32'h00100093);
        check("l2_flush_ready", byte_ready, 0);
        tick();
        check("l2_cpu_run", cpu_run, 1);
        check("l2_load_done", load_done, 1);
        check("l2_word_count", word_count, 2);
        check("l2_stall", fetch_stall, 0);
        tick();
        check("l2_done_pulse", load_done, 0);
        check("l2_mem0", mem[0], 32'h00000013);
        check("l2_mem1", mem[1], 32'h00100093);
        check("l2_writes", wr_cnt, 2);
        $display("load: 8 bytes -> 2 words");

        // fetches
        fetch_req = 1'b1; fetch_addr = 32'h4; #1;
        check("f4_mem_re", mem_re, 1);
        check("f4_mem_addr", mem_addr, 1);
        tick();
        fetch_req = 1'b0;
        check("f4_valid", fetch_valid, 1);
        check("f4_data", fetch_data, 32'h00100093);
        check("f4_fault", fetch_fault, 0);
        $display("fetch: addr 0x4");
        fetch_req = 1'b1; fetch_addr = 32'h6; #1;
        check("f6_mem_re", mem_re, 0);
        tick();
        fetch_req = 1'b0;
        check("f6_valid", fetch_valid, 1);
        check("f6_fault", fetch_fault, 1);
        check("f6_data", fetch_data, 32'h00000013);
        $display("fetch: addr 0x6 misaligned");
        fetch_req = 1'b1; fetch_addr = 32'h400; #1;
        check("f400_mem_re", mem_re, 0);
        tick();
        fetch_req = 1'b0;
        check("f400_fault", fetch_fault, 1);
        check("f400_data", fetch_data, 32'h00000013);
        $display("fetch: addr 0x400 out of range");
        fetch_req = 1'b1; fetch_addr = 32'h0;
        tick();
        fetch_addr = 32'h4;
        check("bb0_valid", fetch_valid, 1);
        check("bb0_data", fetch_data, 32'h00000013);
        tick();
        fetch_addr = 32'h3;
        check("bb1_valid", fetch_valid, 1);
        check("bb1_data", fetch_data, 32'h00100093);
        check("bb1_fault", fetch_fault, 0);
        tick();
        fetch_req = 1'b0;
        check("bb2_fault", fetch_fault, 1);
        check("bb2_data", fetch_data, 32'h00000013);
        tick();
        check("bb3_valid", fetch_valid, 0);
        check("bb3_fault", fetch_fault, 0);
        $display("fetch: 3 back-to-back");

        // partial final word with gaps, reload from RUN
        start_load();
        check("l3_cpu_run", cpu_run, 0);
        check("l3_word_count", word_count, 0);
        for (int i = 0; i < 8; i++) begin
            byte_valid = img3_v[i];
            byte_data  = img3_d[i];
            byte_last  = (i == 7);
            tick();
        end
        byte_valid = 1'b0; byte_last = 1'b0;
        check("l3_flush_addr", mem_addr, 1);
        check("l3_flush_data", mem_wdata, 32'h00000055);
        tick();
        check("l3_word_count_run", word_count, 2);
        check("l3_load_done", load_done, 1);
        check("l3_mem0", mem[0], 32'h44332211);
        check("l3_mem1", mem[1], 32'h00000055);
        $display("load: 5 bytes with gaps -> 2 words");

        // overflow
        start_load();
        wr_base = wr_cnt;
        for (int i = 0; i < 1025; i++) begin
            send_byte(8'(i), 1'b0);
        end
        check("ov_load_err", load_err, 1);
        check("ov_byte_ready", byte_ready, 0);
        check("ov_cpu_run", cpu_run, 0);
        check("ov_word_count", word_count, 256);
        check("ov_writes", wr_cnt - wr_base, 256);
        check("ov_mem0", mem[0], 32'h03020100);
        check("ov_mem255", mem[255], 32'hFFFEFDFC);
        tick();
        check("ov_sticky", load_err, 1);
        check("ov_no_we", mem_we, 0);
        start_load();
        check("ov_err_clear", load_err, 0);
        check("ov_reload_ready", byte_ready, 1);
        $display("load: 1025 bytes -> overflow");

        // reset mid-load
        for (int i = 0; i < 3; i++) send_byte(img2[i], 1'b0);
        wr_base = wr_cnt;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        check("r6_no_write", wr_cnt - wr_base, 0);
        check("r6_cpu_run", cpu_run, 0);
        check("r6_stall", fetch_stall, 1);
        check("r6_byte_ready", byte_ready, 0);
        check("r6_word_count", word_count, 0);
        start_load();
        for (int i = 0; i < 4; i++) send_byte(img6[i], i == 3);
        check("r6_flush_data", mem_wdata, 32'hDDCCBBAA);
        check("r6_flush_addr", mem_addr, 0);
        tick();
        check("r6_word_count_run", word_count, 1);
        check("r6_mem0", mem[0], 32'hDDCCBBAA);
        $display("load: after mid-load reset, 4 bytes -> 1 word");

        // reload request together with a fetch
        load_start = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h0; #1;
        check("r6_mem_re", mem_re, 1);
        tick();
        load_start = 1'b0;
        check("r6_fetch_valid", fetch_valid, 1);
        check("r6_fetch_data", fetch_data, 32'hDDCCBBAA);
        check("r6_cpu_run_drop", cpu_run, 0);
        check("r6_stall_on", fetch_stall, 1);
        check("r6_fetch_ignored", mem_re, 0);
        tick();
        fetch_req = 1'b0;
        check("r6_no_resp", fetch_valid, 0);
        $display("fetch: with load_start in RUN");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
